// File: rtl/mgt01_fp_exec_scheduler_if.sv
// mgt01_fp_exec_scheduler_if: issue, control, clock-enable and writeback signals of the FP issue scheduler
//   master: issue source/controller (drives issue_valid/unit/tag, stall, flush)
//   slave : scheduler (drives issue_ready, *_clk_en, div_start, wb_*, busy)
interface mgt01_fp_exec_scheduler_if #(parameter int TAG_W = 4);
    logic             issue_valid;
    logic [1:0]       issue_unit;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_ready;
    logic             stall;
    logic             flush;
    logic             mag_clk_en;
    logic             add_clk_en;
    logic             mul_clk_en;
    logic             div_clk_en;
    logic             div_start;
    logic             wb_valid;
    logic [1:0]       wb_unit;
    logic [TAG_W-1:0] wb_tag;
    logic             busy;
    modport master (
        output issue_valid, issue_unit, issue_tag, stall, flush,
        input  issue_ready, mag_clk_en, add_clk_en, mul_clk_en, div_clk_en, div_start,
               wb_valid, wb_unit, wb_tag, busy
    );
    modport slave (
        input  issue_valid, issue_unit, issue_tag, stall, flush,
        output issue_ready, mag_clk_en, add_clk_en, mul_clk_en, div_clk_en, div_start,
               wb_valid, wb_unit, wb_tag, busy
    );
endinterface

// File: rtl/mgt01_fp_exec_scheduler.sv
// mgt01_fp_exec_scheduler: FPU issue scheduler dispatching to MAG/ADD/MUL/DIV with writeback-slot reservation and clock gating
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mgt01_fp_exec_scheduler_if (issue handshake, stall/flush, unit clock enables, writeback, busy)
module mgt01_fp_exec_scheduler #(
    parameter int TAG_W   = 4,
    parameter int MAG_LAT = 2,
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 12
) (
    input logic                      clk,
    input logic                      rst_n,
    mgt01_fp_exec_scheduler_if.slave bus
);
    localparam int CW = $clog2(DIV_LAT + 1);
    // entry i holds the op that writes back i cycles from now
    logic [DIV_LAT-1:0] tv;
    logic [1:0]         tu [DIV_LAT];
    logic [TAG_W-1:0]   tt [DIV_LAT];
    logic [CW-1:0]      cnt [4];
    logic               div_busy;
    logic [CW-1:0]      lat;
    logic [DIV_LAT:0]   occ;
    logic               wb_valid;
    logic               div_wb;
    logic               ready;
    logic               fire;
    logic [3:0]         fire_v;
    logic [3:0]         wb_v;
    logic [3:0]         en_v;
    always_comb begin
        lat = bus.issue_unit == 2'd0 ? CW'(MAG_LAT) :
              bus.issue_unit == 2'd1 ? CW'(ADD_LAT) :
              bus.issue_unit == 2'd2 ? CW'(MUL_LAT) : CW'(DIV_LAT);
        // slot DIV_LAT is never occupied: a fire writes at most entry DIV_LAT-1
        occ = {1'b0, tv};
        wb_valid = tv[0] & !bus.stall;
        div_wb = wb_valid & (tu[0] == 2'd3);
        // the DIV writing back this cycle frees the divider for a new DIV
        ready = rst_n & !bus.stall & !bus.flush & !occ[lat] &
                !((bus.issue_unit == 2'd3) & div_busy & !div_wb);
        fire = bus.issue_valid & ready;
        fire_v = fire ? 4'b1 << bus.issue_unit : 4'b0;
        wb_v = wb_valid ? 4'b1 << tu[0] : 4'b0;
        // a unit keeps its clock only while some op other than the one leaving still needs it
        for (int u = 0; u < 4; u++)
            en_v[u] = !bus.stall & (fire_v[u] | (cnt[u] != CW'(wb_v[u])));
    end
    assign bus.issue_ready = ready;
    assign bus.wb_valid    = wb_valid;
    assign bus.wb_unit     = wb_valid ? tu[0] : 2'd0;
    assign bus.wb_tag      = wb_valid ? tt[0] : '0;
    assign bus.div_start   = fire_v[3];
    assign bus.mag_clk_en  = en_v[0];
    assign bus.add_clk_en  = en_v[1];
    assign bus.mul_clk_en  = en_v[2];
    assign bus.div_clk_en  = en_v[3];
    assign bus.busy        = (|tv) | div_busy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv       <= '0;
            div_busy <= 1'b0;
            for (int i = 0; i < DIV_LAT; i++) begin
                tu[i] <= '0;
                tt[i] <= '0;
            end
            for (int u = 0; u < 4; u++) cnt[u] <= '0;
        end else if (bus.flush) begin
            tv       <= '0;
            div_busy <= 1'b0;
            for (int u = 0; u < 4; u++) cnt[u] <= '0;
        end else if (!bus.stall) begin
            tv <= {1'b0, tv[DIV_LAT-1:1]};
            for (int i = 0; i < DIV_LAT - 1; i++) begin
                tu[i] <= tu[i+1];
                tt[i] <= tt[i+1];
            end
            tu[DIV_LAT-1] <= '0;
            tt[DIV_LAT-1] <= '0;
            if (fire) begin
                tv[lat - CW'(1)] <= 1'b1;
                tu[lat - CW'(1)] <= bus.issue_unit;
                tt[lat - CW'(1)] <= bus.issue_tag;
            end
            div_busy <= fire_v[3] | (div_busy & !div_wb);
            for (int u = 0; u < 4; u++) cnt[u] <= cnt[u] + CW'(fire_v[u]) - CW'(wb_v[u]);
        end
    end
endmodule
